cache_controller_2way: RTL and testbench
========================================

Name: cache_controller_2way

Overview:
Control FSM for a parametrised 2-way set-associative, write-back, write-allocate data cache between the single-cycle core and main memory. It compares the request tag against both ways of the indexed set and keeps one LRU bit per set. On a miss it picks a victim, writes it back if dirty, then refills. It drives cache/memory enables and stalls the core, and provides saturating hit/miss counters for performance measurement.

Parameters:
ADDRESS_WIDTH, 10, byte/word address width of i_Address.
INDEX_WIDTH, 4, set index bits; sets = 2^INDEX_WIDTH.
OFFSET_WIDTH, 3, block offset bits.
TAG_SIZE, ADDRESS_WIDTH-INDEX_WIDTH-OFFSET_WIDTH, tag width (derived localparam, not overridable).
COUNT_WIDTH, 16, width of hit/miss counters.

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous active-high reset
i_MemRead / i_MemWrite  in  1 each  core request (both high = write)
i_Address  in  ADDRESS_WIDTH  request address {tag,index,offset}
i_TagWay0 / i_TagWay1  in  TAG_SIZE each  tags of indexed set
i_ValidWay0 / i_ValidWay1  in  1 each  valid bits of indexed set
i_DirtyWay0 / i_DirtyWay1  in  1 each  dirty bits of indexed set
i_MemReady  in  1  main memory completes current transfer
o_WriteEnableCache  out  1  write core data into way o_WaySelect (sets dirty)
o_Replace  out  1  load refill block into way o_WaySelect, tag<=request tag, valid=1, dirty=0
o_WaySelect  out  1  target way for cache writes/reads/replace
o_WriteEnableMainMemory  out  1  write-back request, held until ready
o_ReadEnable  out  1  refill read request, held until ready
o_MemAddress  out  ADDRESS_WIDTH  block address for memory, offset bits zero
o_Hit_Or_Miss  out  1  combinational: 1 = hit in either way
o_Stall  out  1  combinational stall to core
o_HitCount / o_MissCount  out  COUNT_WIDTH each  saturating counters

Behaviour:
- All reset is synchronous on i_reset: state=IDLE. All registered outputs, r_done, r_miss_pending, the LRU array and both counters go to 0. Reset wins over every other event, including an in-flight memory transfer.
- hitN = i_ValidWayN & (i_TagWayN == i_Address[ADDRESS_WIDTH-1 -: TAG_SIZE]). o_Hit_Or_Miss = hit0|hit1. Hit way = hit1 ? 1 : 0.
- o_Stall = (i_MemRead|i_MemWrite) & ~r_done. r_done is a registered one-cycle pulse.
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE, REFILL. All control outputs are registered and valid in the cycle named.
- IDLE: a request with r_done=0 -> COMPARE. A request with r_done=1 is the request just completed, so it is ignored and the state stays IDLE.
- COMPARE, hit:
  - Read: r_done=1 next cycle.
  - Write: o_WriteEnableCache=1 and r_done=1 next cycle.
  - o_WaySelect=hit way. LRU[index] <= ~hit way. Next state is IDLE.
  - o_HitCount increments only if r_miss_pending=0. r_miss_pending is cleared.
- COMPARE, miss:
  - Victim = way0 if invalid, else way1 if invalid, else LRU[index]. Latch the victim.
  - o_MissCount increments. r_miss_pending=1.
  - Victim valid&dirty -> WRITE_BACK with o_WriteEnableMainMemory=1 and o_MemAddress={victim tag,index,0}.
  - Otherwise -> ALLOCATE with o_ReadEnable=1 and o_MemAddress={request tag,index,0}.
- COMPARE, request dropped (both low): -> IDLE, no counter or LRU change.
- WRITE_BACK: hold enable and address. When i_MemReady is sampled high -> ALLOCATE. Next cycle drops the write enable and raises o_ReadEnable with the refill address.
- ALLOCATE: hold o_ReadEnable. When i_MemReady is sampled high -> REFILL.
- REFILL: one cycle with o_Replace=1 and o_WaySelect=victim. Next state is COMPARE, which now hits.
- A memory transfer already started is never aborted except by reset. If the request drops during a transfer, the transfer and refill complete, then COMPARE returns to IDLE.
- Latency from request-high cycle 0 (stall deasserts in the stated cycle):
  - Hit: stall deasserts in cycle 2.
  - Clean miss with ready on the first ALLOCATE cycle: cycle 5.
  - Dirty miss: 1 cycle later, plus any memory wait cycles.
- Counters saturate at all-ones and do not wrap.

Test Plan:
Reset with i_reset=1 for 2 cycles mid-WRITE_BACK -> state IDLE, all outputs 0, counters 0, o_WriteEnableMainMemory low next cycle.
Cold read 0x1A8 (tag 3, index 5), both ways invalid, i_MemReady=1 immediately -> o_ReadEnable with o_MemAddress=0x1A8, o_Replace way0, re-hit, stall low in cycle 5, MissCount=1, HitCount=0.
Write hit on way1, tag 3, index 5 -> o_WriteEnableCache=1 with o_WaySelect=1 in cycle 2, stall low in cycle 2, LRU[5]=0, HitCount+1.
Both ways valid, LRU[5]=1, way1 dirty tag 6, read tag 2 -> WRITE_BACK addr 0x328 held 3 cycles with ready low. Then ALLOCATE addr 0x128, o_Replace way1.
Request held high in cycle of r_done -> no second COMPARE, so no double count and no second write pulse.
Counters preset near max via COUNT_WIDTH=2 and 4 hits -> o_HitCount stays 3.

Source files
------------

// File: rtl/cache_controller_2way_if.sv
// Signal bundle between the 2-way cache controller, the core, the tag/data
// arrays and main memory. The controller uses the slave modport.
interface cache_controller_2way_if #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int INDEX_WIDTH   = 4,
    parameter int OFFSET_WIDTH  = 3,
    parameter int COUNT_WIDTH   = 16
);
    localparam int TAG_SIZE = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    // Core request
    logic                     i_MemRead;
    logic                     i_MemWrite;
    logic [ADDRESS_WIDTH-1:0] i_Address;

    // Contents of the indexed set
    logic [TAG_SIZE-1:0]      i_TagWay0;
    logic [TAG_SIZE-1:0]      i_TagWay1;
    logic                     i_ValidWay0;
    logic                     i_ValidWay1;
    logic                     i_DirtyWay0;
    logic                     i_DirtyWay1;

    // Main memory handshake
    logic                     i_MemReady;

    // Controller outputs
    logic                     o_WriteEnableCache;
    logic                     o_Replace;
    logic                     o_WaySelect;
    logic                     o_WriteEnableMainMemory;
    logic                     o_ReadEnable;
    logic [ADDRESS_WIDTH-1:0] o_MemAddress;
    logic                     o_Hit_Or_Miss;
    logic                     o_Stall;
    logic [COUNT_WIDTH-1:0]   o_HitCount;
    logic [COUNT_WIDTH-1:0]   o_MissCount;

    modport slave (
        input  i_MemRead, i_MemWrite, i_Address,
        input  i_TagWay0, i_TagWay1, i_ValidWay0, i_ValidWay1,
        input  i_DirtyWay0, i_DirtyWay1, i_MemReady,
        output o_WriteEnableCache, o_Replace, o_WaySelect,
        output o_WriteEnableMainMemory, o_ReadEnable, o_MemAddress,
        output o_Hit_Or_Miss, o_Stall, o_HitCount, o_MissCount
    );

    modport master (
        output i_MemRead, i_MemWrite, i_Address,
        output i_TagWay0, i_TagWay1, i_ValidWay0, i_ValidWay1,
        output i_DirtyWay0, i_DirtyWay1, i_MemReady,
        input  o_WriteEnableCache, o_Replace, o_WaySelect,
        input  o_WriteEnableMainMemory, o_ReadEnable, o_MemAddress,
        input  o_Hit_Or_Miss, o_Stall, o_HitCount, o_MissCount
    );
endinterface

// File: rtl/cache_controller_2way.sv
// Control FSM for a 2-way set-associative write-back/write-allocate cache:
// tag compare, per-set LRU, dirty victim write-back, refill, hit/miss counters.
module cache_controller_2way #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int INDEX_WIDTH   = 4,
    parameter int OFFSET_WIDTH  = 3,
    parameter int COUNT_WIDTH   = 16
) (
    input logic                   i_clk,
    input logic                   i_reset,
    cache_controller_2way_if.slave bus
);
    localparam int TAG_SIZE = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int SETS     = 1 << INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE,
        REFILL
    } state_t;

    state_t                   state_q, state_d;
    logic                     done_q, done_d;
    logic                     miss_pending_q, miss_pending_d;
    logic                     we_cache_q, we_cache_d;
    logic                     replace_q, replace_d;
    logic                     way_sel_q, way_sel_d;
    logic                     we_mem_q, we_mem_d;
    logic                     re_q, re_d;
    logic                     victim_q, victim_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [ADDRESS_WIDTH-1:0] refill_addr_q, refill_addr_d;
    logic [COUNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
    logic [COUNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;
    logic [SETS-1:0]          lru_q, lru_d;

    logic [TAG_SIZE-1:0]      req_tag;
    logic [INDEX_WIDTH-1:0]   req_index;
    logic                     req;
    logic                     hit0, hit1, hit, hit_way;
    logic                     victim, victim_dirty;
    logic [TAG_SIZE-1:0]      victim_tag;
    logic [ADDRESS_WIDTH-1:0] req_blk_addr, victim_blk_addr;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign req_tag   = bus.i_Address[ADDRESS_WIDTH-1 -: TAG_SIZE];
    assign req_index = bus.i_Address[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req       = bus.i_MemRead | bus.i_MemWrite;

    assign hit0    = bus.i_ValidWay0 & (bus.i_TagWay0 == req_tag);
    assign hit1    = bus.i_ValidWay1 & (bus.i_TagWay1 == req_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;

    // Fill an empty way before evicting; only a full set consults the LRU bit.
    assign victim       = !bus.i_ValidWay0 ? 1'b0 :
                          !bus.i_ValidWay1 ? 1'b1 : lru_q[req_index];
    assign victim_dirty = victim ? (bus.i_ValidWay1 & bus.i_DirtyWay1)
                                 : (bus.i_ValidWay0 & bus.i_DirtyWay0);
    assign victim_tag   = victim ? bus.i_TagWay1 : bus.i_TagWay0;

    assign req_blk_addr    = {req_tag, req_index, {OFFSET_WIDTH{1'b0}}};
    assign victim_blk_addr = {victim_tag, req_index, {OFFSET_WIDTH{1'b0}}};

    always_comb begin
        state_d        = state_q;
        done_d         = 1'b0;
        miss_pending_d = miss_pending_q;
        we_cache_d     = 1'b0;
        replace_d      = 1'b0;
        way_sel_d      = way_sel_q;
        we_mem_d       = we_mem_q;
        re_d           = re_q;
        victim_d       = victim_q;
        mem_addr_d     = mem_addr_q;
        refill_addr_d  = refill_addr_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        lru_d          = lru_q;

        case (state_q)
            IDLE: begin
                we_mem_d = 1'b0;
                re_d     = 1'b0;
                // With done_q high the request on the bus is the one just served.
                if (req && !done_q) state_d = COMPARE;
            end

            COMPARE: begin
                if (!req) begin
                    state_d        = IDLE;
                    miss_pending_d = 1'b0;
                end else if (hit) begin
                    done_d           = 1'b1;
                    we_cache_d       = bus.i_MemWrite;
                    way_sel_d        = hit_way;
                    lru_d[req_index] = ~hit_way;
                    // The re-compare after a refill was already counted as a miss.
                    if (!miss_pending_q) hit_cnt_d = sat_inc(hit_cnt_q);
                    miss_pending_d   = 1'b0;
                    state_d          = IDLE;
                end else begin
                    victim_d       = victim;
                    way_sel_d      = victim;
                    miss_cnt_d     = sat_inc(miss_cnt_q);
                    miss_pending_d = 1'b1;
                    refill_addr_d  = req_blk_addr;
                    if (victim_dirty) begin
                        state_d    = WRITE_BACK;
                        we_mem_d   = 1'b1;
                        mem_addr_d = victim_blk_addr;
                    end else begin
                        state_d    = ALLOCATE;
                        re_d       = 1'b1;
                        mem_addr_d = req_blk_addr;
                    end
                end
            end

            WRITE_BACK: begin
                if (bus.i_MemReady) begin
                    state_d    = ALLOCATE;
                    we_mem_d   = 1'b0;
                    re_d       = 1'b1;
                    mem_addr_d = refill_addr_q;
                end
            end

            ALLOCATE: begin
                if (bus.i_MemReady) begin
                    state_d   = REFILL;
                    re_d      = 1'b0;
                    replace_d = 1'b1;
                    way_sel_d = victim_q;
                end
            end

            REFILL: begin
                state_d = COMPARE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q        <= IDLE;
            done_q         <= 1'b0;
            miss_pending_q <= 1'b0;
            we_cache_q     <= 1'b0;
            replace_q      <= 1'b0;
            way_sel_q      <= 1'b0;
            we_mem_q       <= 1'b0;
            re_q           <= 1'b0;
            victim_q       <= 1'b0;
            mem_addr_q     <= '0;
            refill_addr_q  <= '0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
            lru_q          <= '0;
        end else begin
            state_q        <= state_d;
            done_q         <= done_d;
            miss_pending_q <= miss_pending_d;
            we_cache_q     <= we_cache_d;
            replace_q      <= replace_d;
            way_sel_q      <= way_sel_d;
            we_mem_q       <= we_mem_d;
            re_q           <= re_d;
            victim_q       <= victim_d;
            mem_addr_q     <= mem_addr_d;
            refill_addr_q  <= refill_addr_d;
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            lru_q          <= lru_d;
        end
    end

    assign bus.o_WriteEnableCache      = we_cache_q;
    assign bus.o_Replace               = replace_q;
    assign bus.o_WaySelect             = way_sel_q;
    assign bus.o_WriteEnableMainMemory = we_mem_q;
    assign bus.o_ReadEnable            = re_q;
    assign bus.o_MemAddress            = mem_addr_q;
    assign bus.o_Hit_Or_Miss           = hit;
    assign bus.o_Stall                 = req & ~done_q;
    assign bus.o_HitCount              = hit_cnt_q;
    assign bus.o_MissCount             = miss_cnt_q;
endmodule

// File: tb/tb_cache_controller_2way.sv
// Bench for cache_controller_2way: directed scenarios then random traffic,
// checked against a transaction-level cache model; a 2-bit-counter copy checks saturation.
module tb_cache_controller_2way;
    localparam int AW   = 10;
    localparam int IW   = 4;
    localparam int OW   = 3;
    localparam int SETS = 16;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cache_controller_2way_if #(.ADDRESS_WIDTH(AW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .COUNT_WIDTH(16)) bus ();
    cache_controller_2way_if #(.ADDRESS_WIDTH(AW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .COUNT_WIDTH(2))  bus2 ();

    cache_controller_2way #(.ADDRESS_WIDTH(AW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .COUNT_WIDTH(16)) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus)
    );
    cache_controller_2way #(.ADDRESS_WIDTH(AW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .COUNT_WIDTH(2)) dut_sat (
        .i_clk(clk), .i_reset(rst), .bus(bus2)
    );

    assign bus2.i_MemRead   = bus.i_MemRead;
    assign bus2.i_MemWrite  = bus.i_MemWrite;
    assign bus2.i_Address   = bus.i_Address;
    assign bus2.i_TagWay0   = bus.i_TagWay0;
    assign bus2.i_TagWay1   = bus.i_TagWay1;
    assign bus2.i_ValidWay0 = bus.i_ValidWay0;
    assign bus2.i_ValidWay1 = bus.i_ValidWay1;
    assign bus2.i_DirtyWay0 = bus.i_DirtyWay0;
    assign bus2.i_DirtyWay1 = bus.i_DirtyWay1;
    assign bus2.i_MemReady  = bus.i_MemReady;

    // Tag array as written by the DUT's enables
    logic [2:0] e_tag   [2][SETS];
    logic       e_valid [2][SETS];
    logic       e_dirty [2][SETS];
    // Reference model of the cache state
    logic [2:0] m_tag   [2][SETS];
    logic       m_valid [2][SETS];
    logic       m_dirty [2][SETS];
    logic       m_lru   [SETS];
    int         m_hits, m_misses;

    int n_checks = 0;
    int n_err    = 0;
    int wait_n   = 0;
    int busy     = 0;
    int phase    = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        logic [3:0] i;
        i = bus.i_Address[6:3];
        bus.i_TagWay0   = e_tag[0][i];
        bus.i_TagWay1   = e_tag[1][i];
        bus.i_ValidWay0 = e_valid[0][i];
        bus.i_ValidWay1 = e_valid[1][i];
        bus.i_DirtyWay0 = e_dirty[0][i];
        bus.i_DirtyWay1 = e_dirty[1][i];
    endtask

    // Memory answers after wait_n cycles of each held enable.
    task automatic drive_ready();
        int ph;
        ph = bus.o_WriteEnableMainMemory ? 1 : (bus.o_ReadEnable ? 2 : 0);
        if (ph != phase) busy = 0;
        phase = ph;
        bus.i_MemReady = (ph != 0) && (busy >= wait_n);
        if (ph != 0) busy++;
    endtask

    task automatic step();
        logic rep, wec, way;
        logic [9:0] a;
        logic [3:0] i;
        rep = bus.o_Replace;
        wec = bus.o_WriteEnableCache;
        way = bus.o_WaySelect;
        a   = bus.i_Address;
        @(posedge clk);
        #1;
        i = a[6:3];
        if (rep === 1'b1) begin
            e_tag[way][i]   = a[9:7];
            e_valid[way][i] = 1'b1;
            e_dirty[way][i] = 1'b0;
        end
        if (wec === 1'b1) e_dirty[way][i] = 1'b1;
        drive_inputs();
        drive_ready();
        #1;
    endtask

    task automatic set_line(input logic way, input logic [3:0] i, input logic [2:0] t,
                            input logic v, input logic d);
        e_tag[way][i] = t;  e_valid[way][i] = v;  e_dirty[way][i] = d;
        m_tag[way][i] = t;  m_valid[way][i] = v;  m_dirty[way][i] = d;
    endtask

    task automatic check_quiet(input string p);
        check({p, "_wecache"},   bus.o_WriteEnableCache, 0);
        check({p, "_replace"},   bus.o_Replace, 0);
        check({p, "_waysel"},    bus.o_WaySelect, 0);
        check({p, "_wemem"},     bus.o_WriteEnableMainMemory, 0);
        check({p, "_readen"},    bus.o_ReadEnable, 0);
        check({p, "_memaddr"},   bus.o_MemAddress, 0);
        check({p, "_stall"},     bus.o_Stall, 0);
        check({p, "_hitcnt"},    bus.o_HitCount, 0);
        check({p, "_misscnt"},   bus.o_MissCount, 0);
        check({p, "_sathit"},    bus2.o_HitCount, 0);
    endtask

    task automatic idle(input int n);
        bus.i_MemRead  = 1'b0;
        bus.i_MemWrite = 1'b0;
        repeat (n) step();
    endtask

    // One core request starting next cycle; returns with the request still high
    // in the cycle the stall drops, so the caller may idle or issue back-to-back.
    task automatic run_req(input logic [9:0] addr, input logic wr, input int w);
        logic [2:0] tg;
        logic [3:0] idx;
        logic [9:0] blk, wb_exp, wb_a, re_a;
        logic       h0, h1, ehit, way, ewb, rep_w, wec_w;
        int         elat, lat, n_wb, n_re, n_rep, n_wec;
        tg  = addr[9:7];
        idx = addr[6:3];
        blk = {addr[9:3], 3'b000};
        h0 = m_valid[0][idx] && (m_tag[0][idx] == tg);
        h1 = m_valid[1][idx] && (m_tag[1][idx] == tg);
        ehit = h0 || h1;
        way = h1;
        ewb = 1'b0;
        wb_exp = '0;
        elat = 2;
        if (!ehit) begin
            way = !m_valid[0][idx] ? 1'b0 : (!m_valid[1][idx] ? 1'b1 : m_lru[idx]);
            ewb = m_valid[way][idx] && m_dirty[way][idx];
            wb_exp = {m_tag[way][idx], idx, 3'b000};
            elat = ewb ? (6 + 2 * w) : (5 + w);
        end

        step();
        wait_n = w;
        bus.i_Address  = addr;
        bus.i_MemWrite = wr;
        bus.i_MemRead  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        drive_inputs();
        #1;
        check("hit_or_miss", bus.o_Hit_Or_Miss, ehit);
        check("stall_cycle0", bus.o_Stall, 1);

        n_wb = 0; n_re = 0; n_rep = 0; n_wec = 0;
        wb_a = '0; re_a = '0; rep_w = 1'b0; wec_w = 1'b0;
        lat = -1;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) step();
            if (bus.o_WriteEnableMainMemory) begin n_wb++;  wb_a = bus.o_MemAddress; end
            if (bus.o_ReadEnable)            begin n_re++;  re_a = bus.o_MemAddress; end
            if (bus.o_Replace)               begin n_rep++; rep_w = bus.o_WaySelect; end
            if (bus.o_WriteEnableCache)      begin n_wec++; wec_w = bus.o_WaySelect; end
            if (!bus.o_Stall) begin
                lat = c;
                break;
            end
        end

        if (ehit) m_dirty[way][idx] = m_dirty[way][idx] | wr;
        else begin
            m_tag[way][idx]   = tg;
            m_valid[way][idx] = 1'b1;
            m_dirty[way][idx] = wr;
        end
        m_lru[idx] = ~way;
        if (ehit) m_hits++; else m_misses++;

        check("latency", lat, elat);
        check("wb_cycles", n_wb, ewb ? w + 1 : 0);
        if (ewb) check("wb_addr", wb_a, wb_exp);
        check("refill_cycles", n_re, ehit ? 0 : w + 1);
        if (!ehit) check("refill_addr", re_a, blk);
        check("replace_cycles", n_rep, ehit ? 0 : 1);
        if (!ehit) check("replace_way", rep_w, way);
        check("wrcache_cycles", n_wec, wr ? 1 : 0);
        if (wr) check("wrcache_way", wec_w, way);
        check("hit_count", bus.o_HitCount, m_hits);
        check("miss_count", bus.o_MissCount, m_misses);
        check("sat_hit_count", bus2.o_HitCount, (m_hits > 3) ? 3 : m_hits);
        check("sat_miss_count", bus2.o_MissCount, (m_misses > 3) ? 3 : m_misses);
        check("array_tag", e_tag[way][idx], tg);
        check("array_valid", e_valid[way][idx], 1);
    endtask

    initial begin
        logic [9:0] a;
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < SETS; s++) set_line(w[0], s[3:0], 3'd0, 1'b0, 1'b0);
        end
        for (int s = 0; s < SETS; s++) m_lru[s] = 1'b0;
        m_hits = 0;
        m_misses = 0;
        rst = 1'b1;
        bus.i_MemRead = 1'b0;
        bus.i_MemWrite = 1'b0;
        bus.i_Address = '0;
        bus.i_MemReady = 1'b0;
        drive_inputs();
        step();
        step();
        check_quiet("init");
        rst = 1'b0;
        idle(2);

        // Cold read: both ways empty, refill goes to way0
        run_req(10'h1A8, 1'b0, 0);
        idle(2);

        // Write hit on way1 only
        set_line(1'b1, 4'd5, 3'd3, 1'b1, 1'b0);
        set_line(1'b0, 4'd5, 3'd7, 1'b1, 1'b0);
        run_req(10'h1A8, 1'b1, 0);
        idle(2);

        // Read hit on way0 leaves LRU pointing at way1
        run_req(10'h3A8, 1'b0, 0);
        idle(1);

        // Dirty eviction of way1 (tag 6), slow memory
        set_line(1'b1, 4'd5, 3'd6, 1'b1, 1'b1);
        run_req(10'h128, 1'b0, 3);

        // Back-to-back hits: no re-compare of a completed request, counters saturate
        repeat (4) run_req(10'h12C, 1'b0, 0);
        idle(2);

        // Reset in the middle of a write-back
        set_line(1'b0, 4'd9, 3'd1, 1'b1, 1'b1);
        set_line(1'b1, 4'd9, 3'd4, 1'b1, 1'b1);
        step();
        wait_n = 1000;
        bus.i_Address = 10'h2C8;
        bus.i_MemRead = 1'b1;
        drive_inputs();
        #1;
        repeat (3) step();
        check("wb_before_reset", bus.o_WriteEnableMainMemory, 1);
        check("wb_addr_before_reset", bus.o_MemAddress, 10'h0C8);
        rst = 1'b1;
        bus.i_MemRead = 1'b0;
        step();
        check_quiet("rst1");
        step();
        check_quiet("rst2");
        rst = 1'b0;
        m_hits = 0;
        m_misses = 0;
        for (int s = 0; s < SETS; s++) m_lru[s] = 1'b0;
        step();
        check_quiet("post_rst");

        // Random traffic on two sets to force evictions
        for (int n = 0; n < 80; n++) begin
            a = {3'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 4'd5 : 4'd2,
                 3'($urandom_range(0, 7))};
            run_req(a, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
